lsu: RTL and testbench

Load/store unit directly downstream of the ALU in the RV32I core. Takes the effective address computed by the ALU for LOAD/STORE opcodes, plus store data (rs2), and runs a single-outstanding request/grant/rvalid transaction on the data-memory port. It does byte-lane steering and strobes for stores, and lane extraction plus sign/zero extension for loads. It returns one response per accepted access toward writeback.

---
 rtl/lsu_pkg.sv | 41 ++++
 rtl/lsu_load_align.sv | 26 ++
 rtl/lsu.sv | 183 ++++++++++++++++++
 tb/tb_lsu.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I widths, opcodes, funct3 codes,
// FSM state encoding and the access legality check.
package lsu_pkg;

    localparam int OPCODE_WIDTH = 7;
    localparam int FUNCT3_WIDTH = 3;
    localparam int DATA_WIDTH   = 32;

    localparam logic [OPCODE_WIDTH-1:0] OP_LOAD  = 7'b0000011;
    localparam logic [OPCODE_WIDTH-1:0] OP_STORE = 7'b0100011;

    localparam logic [FUNCT3_WIDTH-1:0] F3_B  = 3'd0;
    localparam logic [FUNCT3_WIDTH-1:0] F3_H  = 3'd1;
    localparam logic [FUNCT3_WIDTH-1:0] F3_W  = 3'd2;
    localparam logic [FUNCT3_WIDTH-1:0] F3_BU = 3'd4;
    localparam logic [FUNCT3_WIDTH-1:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    // Legal funct3 for the access direction and naturally aligned address.
    function automatic logic access_ok(input logic is_store,
                                       input logic [FUNCT3_WIDTH-1:0] funct3,
                                       input logic [1:0] addr_lo);
        logic ok;
        case (funct3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = ~addr_lo[0];
            F3_W:    ok = (addr_lo == 2'b00);
            F3_BU:   ok = ~is_store;
            F3_HU:   ok = ~is_store & ~addr_lo[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: selects the addressed lane of the read word and
// sign- or zero-extends it according to funct3.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]              offset,
    input  logic [FUNCT3_WIDTH-1:0] funct3,
    output logic [DATA_WIDTH-1:0]   result
);

    logic [DATA_WIDTH-1:0] lane;

    always_comb begin
        lane = rdata >> {offset, 3'b000};
        case (funct3)
            F3_B:    result = {{24{lane[7]}}, lane[7:0]};
            F3_H:    result = {{16{lane[15]}}, lane[15:0]};
            F3_W:    result = lane;
            F3_BU:   result = {24'b0, lane[7:0]};
            F3_HU:   result = {16'b0, lane[15:0]};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Single-outstanding RV32I load/store unit on a req/gnt/rvalid memory port.
// Optional REQ/WAIT abort timer is enabled by defining LSU_TIMEOUT_EN.
//
// state | meaning
// IDLE  | ready for a new access
// REQ   | mem_req asserted, waiting for mem_gnt
// WAIT  | load granted, waiting for mem_rvalid
// RESP  | one-cycle response pulse toward writeback
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic [FUNCT3_WIDTH-1:0] funct3,
    input  logic [DATA_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [DATA_WIDTH-1:0]   mem_addr,
    output logic [3:0]              mem_wstrb,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic                    mem_gnt,
    input  logic                    mem_rvalid,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    resp_valid,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_err
);

    lsu_state_e state_q, state_d;

    logic                    xfer;
    logic                    is_load_in;
    logic                    is_store_in;
    logic                    legal_in;
    logic [3:0]              wstrb_in;
    logic [DATA_WIDTH-1:0]   wdata_in;

    logic                    store_q;
    logic [FUNCT3_WIDTH-1:0] funct3_q;
    logic [1:0]              offset_q;
    logic [DATA_WIDTH-3:0]   word_q;
    logic [3:0]              wstrb_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    err_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [DATA_WIDTH-1:0]   load_result;
    logic                    timeout_fire;

    assign xfer        = req_valid && (state_q == ST_IDLE);
    assign is_load_in  = (opcode == OP_LOAD);
    assign is_store_in = (opcode == OP_STORE);
    assign legal_in    = access_ok(is_store_in, funct3, addr[1:0]);

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] cnt_q;
    logic             busy;

    assign busy = (state_q == ST_REQ) || (state_q == ST_WAIT);

    // Last permitted busy cycle; a gnt/rvalid arriving here still completes normally.
    assign timeout_fire = busy && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) &&
                          !((state_q == ST_REQ && mem_gnt) || (state_q == ST_WAIT && mem_rvalid));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (busy) begin
            cnt_q <= cnt_q + 1'b1;
        end else begin
            cnt_q <= '0;
        end
    end
`else
    logic unused_timeout;

    assign timeout_fire   = 1'b0;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        case (funct3[1:0])
            2'd0: begin
                wstrb_in = 4'b0001 << addr[1:0];
                wdata_in = {4{wdata[7:0]}};
            end
            2'd1: begin
                wstrb_in = 4'b0011 << {addr[1], 1'b0};
                wdata_in = {2{wdata[15:0]}};
            end
            default: begin
                wstrb_in = 4'b1111;
                wdata_in = wdata;
            end
        endcase
    end

    lsu_load_align u_load_align (
        .rdata  (mem_rdata),
        .offset (offset_q),
        .funct3 (funct3_q),
        .result (load_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (xfer && (is_load_in || is_store_in)) begin
                    state_d = legal_in ? ST_REQ : ST_RESP;
                end
            end
            ST_REQ: begin
                if (mem_gnt) begin
                    state_d = store_q ? ST_RESP : ST_WAIT;
                end else if (timeout_fire) begin
                    state_d = ST_RESP;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid || timeout_fire) begin
                    state_d = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state_q == ST_IDLE);
        mem_req    = (state_q == ST_REQ);
        mem_we     = mem_req && store_q;
        mem_addr   = mem_req ? {word_q, 2'b00} : '0;
        mem_wstrb  = mem_we ? wstrb_q : '0;
        mem_wdata  = mem_we ? wdata_q : '0;
        resp_valid = (state_q == ST_RESP);
        resp_rdata = resp_valid ? rdata_q : '0;
        resp_err   = resp_valid && err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            store_q  <= 1'b0;
            funct3_q <= '0;
            offset_q <= '0;
            word_q   <= '0;
            wstrb_q  <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else if (xfer) begin
            store_q  <= is_store_in;
            funct3_q <= funct3;
            offset_q <= addr[1:0];
            word_q   <= addr[DATA_WIDTH-1:2];
            wstrb_q  <= wstrb_in;
            wdata_q  <= wdata_in;
            err_q    <= ~legal_in;
            rdata_q  <= '0;
        end else if (state_q == ST_WAIT && mem_rvalid) begin
            rdata_q <= load_result;
        end else if (timeout_fire) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Randomized self-checking bench for lsu against a spec-level access model.
module tb_lsu;

    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011;
    localparam logic [6:0] OTHER = 7'b0110011;
`ifdef LSU_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [6:0]  opcode = '0;
    logic [2:0]  funct3 = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    lsu #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .opcode     (opcode),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wstrb  (mem_wstrb),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Access semantics from the architectural rules: size, alignment, lane bytes, extension.
    task automatic model(input bit st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd,
                         output bit err, output logic [3:0] strb,
                         output logic [31:0] wexp, output logic [31:0] rexp);
        int size, off;
        bit legal_f3, signed_ld;
        logic [31:0] v, mask;
        legal_f3  = st ? (f3 <= 2) : (f3 <= 2 || f3 == 4 || f3 == 5);
        size      = 1 << (f3 % 4);
        off       = a % 4;
        err       = !legal_f3 || (a % size != 0);
        signed_ld = (f3 < 4);
        for (int i = 0; i < 4; i++) begin
            strb[i]        = (i >= off) && (i < off + size);
            wexp[8*i +: 8] = wd[8*(i % size) +: 8];
        end
        v = rd >> (8 * off);
        if (size < 4) begin
            mask = (32'd1 << (8 * size)) - 1;
            v = v & mask;
            if (signed_ld && v[8*size-1]) v = v | ~mask;
        end
        rexp = (err || st) ? 32'd0 : v;
    endtask

    // Issue one access; gd = cycles of gnt delay, rdl = cycles between gnt and rvalid.
    task automatic run_txn(input string nm, input logic [6:0] op, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                           input int gd, input int rdl);
        bit st, err;
        logic [3:0] strb;
        logic [31:0] wexp, rexp;
        int kg, kr, busy, k_resp, req_last;
        st = (op == STORE);
        model(st, f3, a, wd, rd, err, strb, wexp, rexp);
        kg   = gd + 1;
        kr   = kg + 1 + rdl;
        busy = st ? kg : kr;
        if (err) begin
            k_resp = 1; req_last = 0;
        end else if (TMO > 0 && busy > TMO) begin
            k_resp = TMO + 1; req_last = (kg < TMO) ? kg : TMO;
            err = 1'b1; rexp = 32'd0;
        end else begin
            k_resp = busy + 1; req_last = kg;
        end
        @(posedge clk); #1;
        req_valid = 1'b1; opcode = op; funct3 = f3; addr = a; wdata = wd;
        check_eq({nm, ".ready_idle"}, 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0; addr = $urandom; wdata = $urandom; funct3 = 3'($urandom);
        for (int k = 1; k <= k_resp; k++) begin
            mem_gnt    = (k == kg) || (!err && k > kg && k < kr && ($urandom % 3 == 0));
            mem_rvalid = (k == kr) || (!err && k < kg && ($urandom % 3 == 0));
            mem_rdata  = (k == kr) ? rd : $urandom;
            check_eq({nm, ".mem_req"}, 32'(mem_req), 32'(k <= req_last));
            check_eq({nm, ".ready_busy"}, 32'(req_ready), 32'd0);
            check_eq({nm, ".resp_valid"}, 32'(resp_valid), 32'(k == k_resp));
            if (k <= req_last) begin
                check_eq({nm, ".mem_addr"}, mem_addr, {a[31:2], 2'b00});
                check_eq({nm, ".mem_we"}, 32'(mem_we), 32'(st));
                if (st) begin
                    check_eq({nm, ".wstrb"}, 32'(mem_wstrb), 32'(strb));
                    check_eq({nm, ".wdata"}, mem_wdata, wexp);
                end
            end
            if (k == k_resp) begin
                check_eq({nm, ".resp_err"}, 32'(resp_err), 32'(err));
                check_eq({nm, ".resp_rdata"}, resp_rdata, rexp);
            end
            @(posedge clk); #1;
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        check_eq({nm, ".pulse_end"}, 32'(resp_valid), 32'd0);
        check_eq({nm, ".ready_back"}, 32'(req_ready), 32'd1);
    endtask

    task automatic drop_txn(input logic [31:0] a);
        @(posedge clk); #1;
        req_valid = 1'b1; opcode = OTHER; funct3 = 3'd2; addr = a;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check_eq("drop.ready", 32'(req_ready), 32'd1);
            check_eq("drop.mem_req", 32'(mem_req), 32'd0);
            check_eq("drop.resp_valid", 32'(resp_valid), 32'd0);
            @(posedge clk); #1;
        end
    endtask

    task automatic check_all_zero(input string nm);
        check_eq({nm, ".ready"}, 32'(req_ready), 32'd1);
        check_eq({nm, ".mem_req"}, 32'(mem_req), 32'd0);
        check_eq({nm, ".mem_we"}, 32'(mem_we), 32'd0);
        check_eq({nm, ".mem_addr"}, mem_addr, 32'd0);
        check_eq({nm, ".wstrb"}, 32'(mem_wstrb), 32'd0);
        check_eq({nm, ".wdata"}, mem_wdata, 32'd0);
        check_eq({nm, ".resp_valid"}, 32'(resp_valid), 32'd0);
        check_eq({nm, ".resp_rdata"}, resp_rdata, 32'd0);
        check_eq({nm, ".resp_err"}, 32'(resp_err), 32'd0);
    endtask

    initial begin
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] a;
        int gmax, rmax;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        run_txn("sw",   STORE, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0);
        run_txn("sb",   STORE, 3'd0, 32'h103, 32'h000000A5, 32'h0, 0, 0);
        run_txn("sh",   STORE, 3'd1, 32'h102, 32'h00001234, 32'h0, 0, 0);
        run_txn("lb",   LOAD,  3'd0, 32'h202, 32'h0, 32'h12807856, 0, 0);
        run_txn("lbu",  LOAD,  3'd4, 32'h202, 32'h0, 32'h12807856, 0, 0);
        run_txn("lh",   LOAD,  3'd1, 32'h202, 32'h0, 32'h12807856, 0, 0);
        run_txn("lw",   LOAD,  3'd2, 32'h200, 32'h0, 32'h12807856, 0, 0);
        run_txn("lh_mis", LOAD, 3'd1, 32'h201, 32'h0, 32'h0, 0, 0);
        run_txn("lw_mis", LOAD, 3'd2, 32'h302, 32'h0, 32'h0, 0, 0);
        run_txn("ld_f3",  LOAD, 3'd3, 32'h300, 32'h0, 32'h0, 0, 0);
        run_txn("st_f3",  STORE, 3'd5, 32'h300, 32'h0, 32'h0, 0, 0);
        run_txn("gnt_dly", STORE, 3'd2, 32'h104, 32'hCAFEF00D, 32'h0, 3, 0);
        drop_txn(32'h500);

        // Reset while waiting for rvalid: abandon silently, ignore the late rvalid.
        @(posedge clk); #1;
        req_valid = 1'b1; opcode = LOAD; funct3 = 3'd2; addr = 32'h400;
        @(posedge clk); #1;
        req_valid = 1'b0; mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_wait");
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            mem_rvalid = 1'b1; mem_rdata = $urandom;
            check_eq("rst_late.resp_valid", 32'(resp_valid), 32'd0);
            check_eq("rst_late.ready", 32'(req_ready), 32'd1);
            @(posedge clk); #1;
        end
        mem_rvalid = 1'b0;

`ifdef LSU_TIMEOUT_EN
        run_txn("tmo_nognt", LOAD, 3'd2, 32'h600, 32'h0, 32'h0, 1000, 0);
        run_txn("tmo_norv",  LOAD, 3'd2, 32'h604, 32'h0, 32'h0, 0, 1000);
        run_txn("tmo_after", STORE, 3'd2, 32'h608, 32'h11223344, 32'h0, 0, 0);
        gmax = 1; rmax = 0;
`else
        gmax = 3; rmax = 3;
`endif

        for (int t = 0; t < 250; t++) begin
            op = ($urandom % 2) ? LOAD : STORE;
            f3 = ($urandom % 4 == 0) ? 3'($urandom) : 3'($urandom % 3);
            if (op == LOAD && $urandom % 3 == 0) f3 = 3'd4 + 3'($urandom % 2);
            a  = $urandom;
            if ($urandom % 2) a[1:0] = 2'b00;
            run_txn("rand", op, f3, a, $urandom, $urandom,
                    int'($urandom_range(0, gmax)), int'($urandom_range(0, rmax)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
